// File: rtl/cr_crcgc_mctx_crc.sv
// cr_crcgc_mctx_crc
// Multi-context reflected CRC engine. Beats from interleaved frames carry a
// context id. Each context keeps its own running CRC and an active flag.
// At end of frame the final CRC is placed in a one-entry result register,
// optionally compared against an expected value, and reported through
// one-cycle status pulses.

module cr_crcgc_mctx_crc #(
  parameter int          CRC_WIDTH  = 32,
  parameter logic [63:0] POLYNOMIAL = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] INIT       = '1,
  parameter logic [63:0] XOROUT     = '1,
  parameter int          DATA_BYTES = 8,
  parameter int          N_CTX      = 4,
  localparam int         CTX_W      = (N_CTX > 1) ? $clog2(N_CTX) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTX_W-1:0]        in_ctx,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_vbytes,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic                    in_chk_en,
  input  logic [CRC_WIDTH-1:0]    in_exp_crc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTX_W-1:0]        out_ctx,
  output logic [CRC_WIDTH-1:0]    out_crc,
  output logic                    out_chk,
  output logic                    out_good,
  output logic                    stat_good,
  output logic                    stat_err,
  output logic                    err_nosof,
  output logic [N_CTX-1:0]        ctx_active
);

  // The polynomial is given MSB-first; the shift-right engine needs it
  // bit-reversed.
  function automatic logic [CRC_WIDTH-1:0] reflect_poly(input logic [CRC_WIDTH-1:0] p);
    logic [CRC_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_WIDTH; i++) begin
      r[i] = p[CRC_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [CRC_WIDTH-1:0] POLY_R = reflect_poly(POLYNOMIAL[CRC_WIDTH-1:0]);
  localparam logic [CRC_WIDTH-1:0] INIT_V = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XOR_V  = XOROUT[CRC_WIDTH-1:0];

  // Byte-serial reflected CRC across one beat. Bytes whose mask bit is
  // clear are skipped entirely, so their data can never leak into the CRC.
  function automatic logic [CRC_WIDTH-1:0] crc_beat(
    input logic [CRC_WIDTH-1:0]    base,
    input logic [8*DATA_BYTES-1:0] data,
    input logic [DATA_BYTES-1:0]   vb
  );
    logic [CRC_WIDTH-1:0] c;
    c = base;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (vb[b]) begin
        c[7:0] = c[7:0] ^ data[8*b +: 8];
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  logic [CRC_WIDTH-1:0] crc_state [N_CTX];
  logic [N_CTX-1:0]     active;

  logic                 accept;
  logic                 ctx_ok;
  logic                 restart;
  logic                 nosof;
  logic [CRC_WIDTH-1:0] base;
  logic [CRC_WIDTH-1:0] nxt;
  logic [CRC_WIDTH-1:0] fin;
  logic                 match;

  // The single result slot frees up in the same cycle it is consumed, so
  // an eof beat can be accepted while the previous result is being taken.
  assign in_ready   = ~out_valid | out_ready;
  assign ctx_active = active;

  // Pick the starting CRC for this beat and fold the valid bytes into it.
  // An idle context, or an explicit sof, starts from INIT.
  always_comb begin
    accept  = in_valid & in_ready;
    ctx_ok  = (32'(in_ctx) < 32'(N_CTX));
    restart = 1'b1;
    nosof   = 1'b0;
    base    = INIT_V;
    if (ctx_ok) begin
      restart = in_sof | ~active[in_ctx];
      nosof   = ~in_sof & ~active[in_ctx];
      if (!restart) begin
        base = crc_state[in_ctx];
      end
    end
    nxt   = crc_beat(base, in_data, in_vbytes);
    fin   = nxt ^ XOR_V;
    match = (fin == in_exp_crc);
  end

  // Per-context running CRC and mid-frame flag. The eof beat returns its
  // context to the idle state so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CTX; i++) begin
        crc_state[i] <= INIT_V;
      end
      active <= '0;
    end else if (accept && ctx_ok) begin
      if (in_eof) begin
        crc_state[in_ctx] <= INIT_V;
        active[in_ctx]    <= 1'b0;
      end else begin
        crc_state[in_ctx] <= nxt;
        active[in_ctx]    <= 1'b1;
      end
    end
  end

  // One-entry result register. A load takes priority over the drain so a
  // simultaneous take-and-reload keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctx   <= '0;
      out_crc   <= '0;
      out_chk   <= 1'b0;
      out_good  <= 1'b0;
    end else if (accept && in_eof) begin
      out_valid <= 1'b1;
      out_ctx   <= in_ctx;
      out_crc   <= fin;
      out_chk   <= in_chk_en;
      out_good  <= in_chk_en & match;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status pulses: check outcome on the result handshake, and a warning
  // when a frame continuation lands on a context that was never started.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good <= 1'b0;
      stat_err  <= 1'b0;
      err_nosof <= 1'b0;
    end else begin
      stat_good <= out_valid & out_ready & out_chk & out_good;
      stat_err  <= out_valid & out_ready & out_chk & ~out_good;
      err_nosof <= accept & nosof;
    end
  end

endmodule

// File: doc/cr_crcgc_mctx_crc.md
# cr_crcgc_mctx_crc

Parametrised multi-context CRC engine for the crcgc datapath. It accumulates a reflected CRC of configurable width and polynomial over byte-masked data beats. Beats from up to N_CTX interleaved frames are tagged by context id, and at end of frame the engine emits the final CRC with an optional compare against an expected value. It sits between the CTS parser and the stats/TLV output path and extends the fixed single-stream CRC instances with context interleaving, a result handshake and built-in checking.

## Interface
- CRC_WIDTH, 32: CRC register width in bits (8..64).
- POLYNOMIAL, 32'h04C11DB7: generator polynomial in normal (MSB-first) form; the engine applies it reflected.
- INIT, all ones: CRC value loaded at start of frame.
- XOROUT, all ones: value XORed into the final CRC.
- DATA_BYTES, 8: bytes per beat.
- N_CTX, 4: number of independent contexts (≥1); CTX_W = max(1,$clog2(N_CTX)).
- clk  in  1  clock.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine accepts the beat.
- in_ctx  in  CTX_W  context id of the beat.
- in_data  in  8*DATA_BYTES  payload; byte 0 = bits [7:0], processed first.
- in_vbytes  in  DATA_BYTES  valid-byte mask, contiguous from bit 0 (0 allowed).
- in_sof / in_eof  in  1  first / last beat of frame.
- in_chk_en  in  1  compare the result on the eof beat.
- in_exp_crc  in  CRC_WIDTH  expected CRC, sampled on the eof beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_ctx  out  CTX_W  context of the result.
- out_crc  out  CRC_WIDTH  final CRC (state ^ XOROUT).
- out_chk / out_good  out  1  a check was done / the check matched.
- stat_good / stat_err  out  1  one-cycle pulse on the result handshake when out_chk=1 and the check passed / failed.
- err_nosof  out  1  one-cycle pulse: accepted beat on an inactive context without sof.
- ctx_active  out  N_CTX  context currently mid-frame.

## Operation
- Per-context flops hold crc_state[N_CTX] and active[N_CTX]. On reset: state=INIT, active=0.
- An accepted beat (in_valid & in_ready):
  - base = INIT if in_sof or !active[ctx], else crc_state[ctx].
  - nxt = reflected CRC of base over the valid bytes in order 0..DATA_BYTES-1; nxt = base when vbytes=0.
  - If in_eof: crc_state[ctx] ← INIT, active[ctx] ← 0, and the result register loads ctx, nxt^XOROUT, chk_en and (nxt^XOROUT == in_exp_crc). Otherwise crc_state[ctx] ← nxt and active[ctx] ← 1.
- sof on an active context restarts the frame silently; the partial CRC is discarded.
- A non-sof beat on an inactive context is processed as if sof were set and pulses err_nosof.
- sof and eof on the same beat form a single-beat frame.
- Result register is one entry. in_ready = !out_valid | out_ready, applied to every beat (eof or not).
- out_good = out_chk & match; out_good is 0 when out_chk=0.
- Non-valid bytes (vbytes bit clear) never affect the CRC, whatever their data.

## Timing
- Accept-to-result latency is 1 cycle: the eof beat is accepted in cycle N and out_valid is high in cycle N+1.
- Context state is updated in the accept cycle. A back-to-back beat on the same ctx sees the updated state with no bubble, giving full throughput of one beat per cycle.
- out_* hold stable while out_valid & !out_ready.
- If the result is taken and a new eof beat is accepted in the same cycle, the register reloads and out_valid stays 1.
- stat_good/stat_err are registered and pulse in the cycle after the result handshake.
- Reset values: out_valid, out_ctx, out_crc, out_chk, out_good, stat_*, err_nosof, ctx_active are all 0. in_ready is 1 from the first cycle after reset.
- Reset mid-frame aborts all contexts. A subsequent non-sof beat pulses err_nosof.

## Test plan
- CRC32 defaults, ctx 0. Beat 1: data 0x3837363534333231, vbytes 0xFF, sof. Beat 2: data 0x39, vbytes 0x01, eof, chk_en, exp 0xCBF43926 → out_crc 0xCBF43926, out_good=1, stat_good pulse, latency 1.
- Same frame with exp 0x00000000 → out_good=0, stat_err pulse. Repeat with chk_en=0 → neither stat pulse.
- Interleave "123456789" on ctx 1 and ctx 2 beat by beat, plus garbage in the masked-off bytes → both results are 0xCBF43926, with out_ctx correct and in order.
- Hold out_ready=0 while eof beats arrive → in_ready drops after the first result, the result stays stable, and no beat or result is lost when out_ready is released.
- sof+eof with vbytes=0 → out_crc 0x00000000. Non-sof beat on idle ctx 3 → err_nosof pulse and a CRC equal to the sof case.
- Assert rst mid-frame on ctx 0 → ctx_active=0 and out_valid=0. A continuation beat gets err_nosof. A new full frame gives the correct CRC.
